addsub_pipe_unit: RTL and testbench
===================================

Name: addsub_pipe_unit

Overview:
- Pipelined add/subtract responder: accepts operand pairs from a driver over a valid/ready handshake and returns results with carry/borrow and overflow flags over a second valid/ready handshake.
- It is the DUT-side counterpart of the bench driver/monitor environment, replacing the bare combinational adder with a stallable 2-stage pipeline.
- Full throughput: one result per cycle when unstalled.

Parameters:
WIDTH, 8, operand/result width in bits (≥2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  unit can accept operands this cycle
op  input  1  0 = add, 1 = subtract (op_e)
in1  input  WIDTH  operand A
in2  input  WIDTH  operand B
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out  output  WIDTH  result
carry  output  1  add: carry-out; sub: borrow (in1 < in2 unsigned)
ovf  output  1  two's-complement signed overflow
txn_cnt  output  16  count of results delivered (out_valid && out_ready), wraps FFFF→0000

Behaviour:
- Reset (rst=0, async, immediate):
  - s1_v=0, s2_v=0, out=0, carry=0, ovf=0, txn_cnt=0, out_valid=0.
  - in_ready=1 in the first cycle after rst releases.
  - Reset mid-operation discards all in-flight data; no partial output.
- Stage 1 (s1): registers op, in1, in2 when in_valid && in_ready.
- Stage 2 (s2): registers the computed out/carry/ovf from s1.
- Advance rules:
  - s2_load = s1_v && (!s2_v || out_ready)
  - s1_load = in_valid && in_ready
  - in_ready = !s1_v || s2_load (combinational, no dependency on in_valid)
  - s1_v next = s1_load || (s1_v && !s2_load)
  - s2_v next = s2_load || (s2_v && !out_ready)
- Latency: operands accepted at edge N → out_valid=1 after edge N+1.
- Stall: while out_valid && !out_ready, out/carry/ovf hold stable. The pipeline absorbs at most 2 entries, then in_ready=0.
- Ordering: strictly in order, no drop, no duplication.
- Simultaneous events: when full, out_ready=1 and in_valid=1 in the same cycle → both stages advance and the new pair is accepted (throughput preserved).
- Arithmetic: computed at WIDTH+1 bits.
  - Add: out = (in1+in2) mod 2^WIDTH; carry = bit WIDTH.
  - Sub: out = (in1-in2) mod 2^WIDTH; carry = 1 iff in1 < in2 unsigned.
  - ovf = operand sign bits agree (add) / differ (sub) and result sign differs from in1 sign.
- txn_cnt increments on each out_valid && out_ready edge.

Optional Feature:
- Macro: ADDSUB_SATURATE_EN.
- Defined: when ovf=1, out clamps to signed max (0111…1) for positive overflow, signed min (1000…0) for negative overflow. ovf and carry are still reported unchanged.
- Undefined: wrap-around result as above; no clamp logic synthesized.

Decomposition:
- Package addsub_pkg:
  - typedef enum logic {OP_ADD=1'b0, OP_SUB=1'b1} op_e
  - struct res_t {out, carry, ovf}, parameterised through a WIDTH localparam default 8
  - localparam CNT_W=16
- Sub-module addsub_core:
  - Purely combinational op/in1/in2 → res_t, including the saturation path under the macro.
  - Instantiated between s1 and s2.

Test Plan (WIDTH=8):
- Reset: pull rst low while s1_v=s2_v=1 → out_valid=0 and txn_cnt=0 immediately (no clock edge); in_ready=1 after release.
- Add: op=0, in1=05, in2=03 accepted at edge N, out_ready=1 → out=08, carry=0, ovf=0, valid after edge N+1.
- Sub with borrow: op=1, in1=03, in2=05 → out=FE, carry=1, ovf=0. Also op=0, FF+01 → out=00, carry=1, ovf=0.
- Overflow: op=0, 7F+01 → ovf=1, out=80 (ADDSUB_SATURATE_EN: out=7F). Also op=1, 80-01 → ovf=1, out=7F (saturate: 80).
- Backpressure: out_ready=0, drive 3 pairs (01+01, 02+02, 03+03).
  - in_ready drops after 2 accepted; third held.
  - Raise out_ready → 02, 04, 06 in order, one per cycle; outputs stable during stall.
- Throughput and counter: 20 back-to-back pairs with out_ready=1 → 20 consecutive result cycles, txn_cnt=20 (0x0014), in_ready never 0.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types and constants for the pipelined add/subtract unit.
// Optional feature macro: ADDSUB_SATURATE_EN (clamp on signed overflow).
package addsub_pkg;

  // Default datapath width used by the result bundle below.
  localparam int ADDSUB_WIDTH = 8;

  // Width of the delivered-result counter.
  localparam int CNT_W = 16;

  // Operation select carried on the op input.
  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Result bundle at the default width: value, carry/borrow, signed overflow.
  typedef struct packed {
    logic [ADDSUB_WIDTH-1:0] out;
    logic                    carry;
    logic                    ovf;
  } res_t;

endpackage

// File: rtl/addsub_core.sv
// Combinational add/subtract core sitting between pipeline stages 1 and 2.
// Optional feature macro: ADDSUB_SATURATE_EN (clamp on signed overflow).
module addsub_core
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_e              i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_out,
  output logic             o_carry,
  output logic             o_ovf
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_wrap;
  logic             w_ovf;

  // One extra bit holds carry-out for add and borrow for subtract.
  always_comb begin
    w_sum = '0;
    if (i_op == OP_SUB) w_sum = {1'b0, i_a} - {1'b0, i_b};
    else                w_sum = {1'b0, i_a} + {1'b0, i_b};
  end

  assign w_wrap = w_sum[WIDTH-1:0];

  // Signed overflow: operand signs agree (add) / differ (sub), and the result sign flips vs i_a.
  always_comb begin
    w_ovf = 1'b0;
    if (i_op == OP_SUB) w_ovf = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_wrap[WIDTH-1] != i_a[WIDTH-1]);
    else                w_ovf = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_wrap[WIDTH-1] != i_a[WIDTH-1]);
  end

  assign o_carry = w_sum[WIDTH];
  assign o_ovf   = w_ovf;

`ifdef ADDSUB_SATURATE_EN
  // Overflow direction follows i_a's sign: positive i_a clamps to max, negative to min.
  always_comb begin
    o_out = w_wrap;
    if (w_ovf) o_out = i_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign o_out = w_wrap;
`endif

endmodule

// File: rtl/addsub_pipe_unit.sv
// Two-stage stallable add/subtract pipeline with valid/ready on both sides.
// Optional feature macro: ADDSUB_SATURATE_EN (clamp on signed overflow).
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid, once raised, is held with stable data until the transfer, and
// ready never depends on the same side's valid.
module addsub_pipe_unit
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             ovf,
  output logic [CNT_W-1:0] txn_cnt
);

  logic             r_s1_v;
  op_e              r_s1_op;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s2_v;
  logic [WIDTH-1:0] r_out;
  logic             r_carry;
  logic             r_ovf;
  logic [CNT_W-1:0] r_txn_cnt;

  logic             w_s1_load;
  logic             w_s2_load;
  logic [WIDTH-1:0] w_out;
  logic             w_carry;
  logic             w_ovf;

  // Stage 2 advances when it is empty or draining; stage 1 accepts when it will be vacated.
  assign w_s2_load = r_s1_v && (!r_s2_v || out_ready);
  assign in_ready  = !r_s1_v || w_s2_load;
  assign w_s1_load = in_valid && in_ready;

  // Stage 1 captures the operand pair.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_v  <= 1'b0;
      r_s1_op <= OP_ADD;
      r_s1_a  <= '0;
      r_s1_b  <= '0;
    end else begin
      r_s1_v <= w_s1_load || (r_s1_v && !w_s2_load);
      if (w_s1_load) begin
        r_s1_op <= op_e'(op);
        r_s1_a  <= in1;
        r_s1_b  <= in2;
      end
    end
  end

  addsub_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i_op    (r_s1_op),
    .i_a     (r_s1_a),
    .i_b     (r_s1_b),
    .o_out   (w_out),
    .o_carry (w_carry),
    .o_ovf   (w_ovf)
  );

  // Stage 2 holds the result; it stays frozen while the consumer stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s2_v  <= 1'b0;
      r_out   <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_s2_v <= w_s2_load || (r_s2_v && !out_ready);
      if (w_s2_load) begin
        r_out   <= w_out;
        r_carry <= w_carry;
        r_ovf   <= w_ovf;
      end
    end
  end

  // Count delivered results; wraps naturally at the counter width.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_txn_cnt <= '0;
    else if (r_s2_v && out_ready) r_txn_cnt <= r_txn_cnt + 1'b1;
  end

  assign out_valid = r_s2_v;
  assign out       = r_out;
  assign carry     = r_carry;
  assign ovf       = r_ovf;
  assign txn_cnt   = r_txn_cnt;

endmodule

// File: tb/tb_addsub_pipe_unit.sv
// Directed bench for addsub_pipe_unit (WIDTH=8). Inputs change and outputs are
// sampled on the falling clock edge, away from the active rising edge.
module tb_addsub_pipe_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        op;
  logic [7:0]  in1;
  logic [7:0]  in2;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out;
  logic        carry;
  logic        ovf;
  logic [15:0] txn_cnt;

  int n_pass;
  int n_total;

  logic [7:0] exp_q[$];

  addsub_pipe_unit #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .carry     (carry),
    .ovf       (ovf),
    .txn_cnt   (txn_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive one operand pair, then check the result two falling edges later.
  task automatic send_one(input string tag, input logic o, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] e_out, input logic e_c, input logic e_v);
    @(negedge clk);
    in_valid = 1'b1; op = o; in1 = a; in2 = b;
    check({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_not_yet_valid"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_out"}, out, e_out);
    check({tag, "_carry"}, carry, e_c);
    check({tag, "_ovf"}, ovf, e_v);
  endtask

  initial begin
    int got;
    int first_cyc;
    int last_cyc;
    logic [7:0] exp_v;
    logic [7:0] a;
    logic [7:0] b;
    n_pass = 0; n_total = 0;
    rst = 1'b0; in_valid = 1'b0; op = 1'b0; in1 = '0; in2 = '0; out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out", out, 8'h00);
    check("rst_txn", txn_cnt, 16'h0000);

    // Arithmetic vectors
    out_ready = 1'b1;
    send_one("add_05_03", 1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0);
    send_one("sub_03_05", 1'b1, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    send_one("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
`ifdef ADDSUB_SATURATE_EN
    send_one("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h7F, 1'b0, 1'b1);
    send_one("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h80, 1'b0, 1'b1);
`else
    send_one("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    send_one("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
`endif
    @(negedge clk);
    check("txn_after_5", txn_cnt, 16'd5);
    check("idle_valid", out_valid, 0);

    // Backpressure: third pair must be held off
    out_ready = 1'b0;
    in_valid = 1'b1; op = 1'b0; in1 = 8'h01; in2 = 8'h01;
    check("bp_rdy1", in_ready, 1);
    @(negedge clk);
    in1 = 8'h02; in2 = 8'h02;
    check("bp_rdy2", in_ready, 1);
    @(negedge clk);
    in1 = 8'h03; in2 = 8'h03;
    check("bp_full_rdy", in_ready, 0);
    check("bp_full_valid", out_valid, 1);
    check("bp_full_out", out, 8'h02);
    @(negedge clk);
    check("bp_stall_rdy", in_ready, 0);
    check("bp_stall_out", out, 8'h02);
    check("bp_stall_txn", txn_cnt, 16'd5);
    out_ready = 1'b1;
    #1;
    check("bp_release_rdy", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_res2_valid", out_valid, 1);
    check("bp_res2_out", out, 8'h04);
    @(negedge clk);
    check("bp_res3_valid", out_valid, 1);
    check("bp_res3_out", out, 8'h06);
    @(negedge clk);
    check("bp_drained", out_valid, 0);
    check("bp_txn", txn_cnt, 16'd8);

    // Reset with both stages occupied
    out_ready = 1'b0;
    in_valid = 1'b1; in1 = 8'h11; in2 = 8'h22;
    repeat (2) @(negedge clk);
    in_valid = 1'b0;
    check("mid_full_valid", out_valid, 1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_txn", txn_cnt, 16'h0000);
    check("mid_rst_out", out, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    check("mid_rel_rdy", in_ready, 1);
    @(negedge clk);
    check("mid_no_stale", out_valid, 0);

    // Throughput: 20 back-to-back pairs with the consumer always ready
    out_ready = 1'b1;
    got = 0; first_cyc = -1; last_cyc = -1;
    for (int cyc = 0; cyc < 26; cyc++) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("tp_unexpected", out_valid, 0);
        end else begin
          exp_v = exp_q.pop_front();
          check("tp_out", out, exp_v);
          got++;
          if (first_cyc < 0) first_cyc = cyc;
          last_cyc = cyc;
        end
      end
      if (cyc < 20) begin
        a = 8'(cyc * 5 + 1);
        b = 8'(cyc * 3);
        in_valid = 1'b1; op = 1'b0; in1 = a; in2 = b;
        check("tp_in_ready", in_ready, 1);
        exp_q.push_back(8'(a + b));
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("tp_count", got, 20);
    check("tp_consecutive", last_cyc - first_cyc + 1, 20);
    check("tp_txn", txn_cnt, 16'h0014);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
